// File: rtl/ysyx_22041461_pmem_responder.sv
// ---------------------------------------------------------------------------
// ysyx_22041461_pmem_responder
//
// Memory-side responder for the caches' single-outstanding load/store
// channel. One request is accepted over req_valid/req_ready. The responder
// waits LATENCY cycles to model memory latency. It then performs the
// physical access through pmem_read / pmem_write and returns the result over
// resp_valid/resp_ready.
//
// Parameters
//   LATENCY      cycles from request acceptance to resp_valid (legal 1..15)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          asynchronous active-low reset
//   req_valid    request fields are valid
//   req_ready    responder can accept a request (registered, IDLE decode)
//   req_addr     64-bit byte address, handed to the memory access unmodified
//   req_wdata    64-bit store data
//   req_mask     store byte mask (ignored for reads)
//   req_wen      1 = write, 0 = read
//   resp_valid   response available (registered, RESP decode)
//   resp_ready   requester accepts the response
//   resp_rdata   read data, zero for write responses
//   resp_wr      req_wen of the transaction being answered
//
// Memory binding
//   pmem_read / pmem_write are provided by a small behavioural memory window
//   at 0x8000_0000 (8 KiB, aligned doublewords only). It keeps call counters
//   so that the number of accesses can be observed.
// ---------------------------------------------------------------------------
module ysyx_22041461_pmem_responder #(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_mask,
    input  logic        req_wen,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_wr
);

    // Behavioural memory. Accesses outside the window, or accesses that are
    // not doubleword aligned, read as zero and drop writes.
    localparam logic [50:0] MODEL_BASE = 51'h4_0000;  // 0x8000_0000 >> 13

    logic [63:0] model_mem [0:1023];
    int          model_rd_cnt;
    int          model_wr_cnt;

    function automatic void pmem_read(input longint raddr, output longint rdata);
        logic [63:0] a;
        a = raddr;
        model_rd_cnt = model_rd_cnt + 1;
        if (a[63:13] == MODEL_BASE && a[2:0] == 3'd0) begin
            rdata = model_mem[a[12:3]];
        end else begin
            rdata = '0;
        end
    endfunction

    function automatic void pmem_write(input longint waddr, input longint wdata,
                                       input byte wmask);
        logic [63:0] a;
        logic [63:0] d;
        logic [63:0] w;
        logic [7:0]  m;
        a = waddr;
        d = wdata;
        m = wmask;
        model_wr_cnt = model_wr_cnt + 1;
        if (a[63:13] == MODEL_BASE && a[2:0] == 3'd0) begin
            w = model_mem[a[12:3]];
            for (int i = 0; i < 8; i++) begin
                if (m[i]) begin
                    w[i*8 +: 8] = d[i*8 +: 8];
                end
            end
            model_mem[a[12:3]] = w;
        end
    endfunction

    typedef enum logic [1:0] {
        RST_WAIT = 2'd0,
        IDLE     = 2'd1,
        WAIT     = 2'd2,
        RESP     = 2'd3
    } state_t;

    // WAIT already accounts for one cycle before the count reaches zero, so the
    // counter is loaded with LATENCY-2. LATENCY=1 bypasses WAIT entirely.
    localparam logic [3:0] WAIT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    state_t      state_reg;
    state_t      state_next;
    logic [3:0]  cnt_reg;
    logic [3:0]  cnt_next;
    logic [63:0] addr_reg;
    logic [63:0] wdata_reg;
    logic [7:0]  mask_reg;
    logic        wen_reg;
    logic [63:0] rdata_reg;
    logic        resp_wr_reg;

    logic        capture;
    logic        enter_resp;
    logic        resp_done;

    // Fields used for the memory access. With LATENCY=1 the access happens on
    // the acceptance edge, before the capture registers are loaded, so the
    // live request is used there. Otherwise only the captured copy is used.
    logic [63:0] acc_addr;
    logic [63:0] acc_wdata;
    logic [7:0]  acc_mask;
    logic        acc_wen;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        enter_resp = 1'b0;
        resp_done  = 1'b0;
        case (state_reg)
            RST_WAIT: begin
                state_next = IDLE;
            end
            IDLE: begin
                if (req_valid) begin
                    capture = 1'b1;
                    if (LATENCY == 1) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        cnt_next   = WAIT_LOAD;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_next = IDLE;
                    resp_done  = 1'b1;
                end
            end
            default: begin
                state_next = RST_WAIT;
            end
        endcase
    end

    always_comb begin
        if (state_reg == IDLE) begin
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_mask  = req_mask;
            acc_wen   = req_wen;
        end else begin
            acc_addr  = addr_reg;
            acc_wdata = wdata_reg;
            acc_mask  = mask_reg;
            acc_wen   = wen_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin : seq
        logic [63:0] rd_word;
        if (!rst) begin
            state_reg   <= RST_WAIT;
            cnt_reg     <= '0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            mask_reg    <= '0;
            wen_reg     <= 1'b0;
            rdata_reg   <= '0;
            resp_wr_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (capture) begin
                addr_reg  <= req_addr;
                wdata_reg <= req_wdata;
                mask_reg  <= req_mask;
                wen_reg   <= req_wen;
            end
            // The access is issued only on the edge that enters RESP, so a stall
            // in RESP never repeats it.
            if (enter_resp) begin
                resp_wr_reg <= acc_wen;
                if (acc_wen) begin
                    pmem_write(acc_addr, acc_wdata, acc_mask);
                    rdata_reg <= '0;
                end else begin
                    pmem_read(acc_addr, rd_word);
                    rdata_reg <= rd_word;
                end
            end else if (resp_done) begin
                rdata_reg <= '0;
            end
        end
    end

    assign req_ready  = (state_reg == IDLE);
    assign resp_valid = (state_reg == RESP);
    assign resp_rdata = rdata_reg;
    assign resp_wr    = resp_wr_reg;

endmodule

// File: doc/ysyx_22041461_pmem_responder.md
# ysyx_22041461_pmem_responder

Memory-side responder for the single-outstanding load/store request channel issued by the data and instruction caches. It accepts one request over a valid/ready handshake, waits a programmable number of cycles to model memory latency, then performs the physical access through the `pmem_read`/`pmem_write` DPI-C functions. It returns the result over a second valid/ready handshake. It sits between the cache refill/write-through path and the simulated physical memory. It replaces the caches' direct combinational DPI calls with a cycle-accurate, back-pressured transaction.

## Interface
- `LATENCY`, default 2: cycles from request acceptance to `resp_valid`. Legal range 1..15.
- `clk` input 1: clock. All state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `req_valid` input 1: the request fields below are valid.
- `req_ready` output 1: the responder can accept a request.
- `req_addr` input 64: byte address, passed to DPI unmodified.
- `req_wdata` input 64: store data.
- `req_mask` input 8: store byte mask. Ignored for reads.
- `req_wen` input 1: 1 = write, 0 = read.
- `resp_valid` output 1: response available.
- `resp_ready` input 1: the requester accepts the response.
- `resp_rdata` output 64: read data. Zero for write responses.
- `resp_wr` output 1: echoes the `req_wen` of the transaction being answered.

## Operation
- FSM states: RST_WAIT, IDLE, WAIT, RESP.
  - Reset enters RST_WAIT.
  - On the first clock edge after reset release, RST_WAIT moves to IDLE.
- IDLE:
  - `req_ready`=1.
  - On `req_valid && req_ready`, capture addr/wdata/mask/wen into internal registers.
  - If `LATENCY`=1, go directly to RESP. Otherwise load the counter with `LATENCY-2` and go to WAIT.
- WAIT:
  - `req_ready`=0.
  - The counter decrements each cycle. At count 0, go to RESP.
  - Request inputs are ignored, so they may change freely.
- Entry into RESP, on the same edge as the transition and exactly once per transaction:
  - Read: call `pmem_read(addr, data)` and register `data` into `resp_rdata`.
  - Write: call `pmem_write(addr, wdata, mask)` and set `resp_rdata`=0.
- RESP:
  - `resp_valid`=1. `resp_rdata` and `resp_wr` stay stable until the handshake.
  - On `resp_valid && resp_ready`, go to IDLE and clear `resp_valid` and `resp_rdata`.
  - No DPI call is repeated while the responder is stalled in RESP.
- Only one transaction is in flight. A new request is never accepted in the same cycle as a response handshake.
- Only the captured copy of the request is used after acceptance.
- Counter width is 4 bits. No wrap-around can occur within the legal `LATENCY` range.

## Timing
- Reset values:
  - `req_ready`=0, `resp_valid`=0, `resp_rdata`=0, `resp_wr`=0.
  - Counter and capture registers are 0.
- `req_ready` and `resp_valid` are registered, decoded from the state register. There is no combinational path from `req_valid` or `resp_ready` to any output.
- Acceptance at edge T gives `resp_valid`=1 from edge T+`LATENCY`.
- With `resp_ready` held at 1:
  - `resp_valid` lasts exactly one cycle.
  - `req_ready` returns at edge T+`LATENCY`+1.
  - Throughput is one transaction per `LATENCY`+1 cycles.
- `resp_ready`=0 stalls RESP indefinitely. Outputs stay constant throughout the stall.
- Reset asserted in WAIT: the transaction is dropped and no DPI call occurs. Outputs return to their reset values immediately (asynchronous).
- Reset asserted in RESP: the response is dropped. The DPI access has already happened.
- `req_valid` asserted during RST_WAIT is not accepted. It is accepted on the first IDLE cycle.

## Test plan
- Read, `LATENCY`=2:
  - Preload memory 0x8000_0008 = 0x1122_3344_5566_7788.
  - Request read at edge T.
  - Required: `resp_valid` at T+2 with `resp_rdata`=0x1122_3344_5566_7788 and `resp_wr`=0. `req_ready` is high again at T+3.
- Masked write then read:
  - Write 0xAABB_CCDD_EEFF_0011 with mask 0x0F to 0x8000_0010 (old value 0).
  - Required: write response with `resp_rdata`=0.
  - A following read returns 0x0000_0000_EEFF_0011.
- Backpressure:
  - Hold `resp_ready`=0 for 5 cycles in RESP.
  - Required: `resp_valid` and `resp_rdata` stay constant, `req_ready`=0, and the DPI read counter increments exactly 1.
- `LATENCY`=1 back-to-back:
  - Hold `req_valid`=1 with 3 reads and `resp_ready`=1.
  - Required: responses 2 cycles apart. No acceptance occurs in any handshake cycle.
- Reset in WAIT:
  - `LATENCY`=4, issue a write to 0x8000_0020, then pull `rst` low 2 cycles after acceptance.
  - Required: all outputs are 0 immediately and memory at 0x8000_0020 is unchanged. After release, `req_ready` is 0 for one cycle, then 1.
- Request changes after acceptance:
  - Change `req_addr`/`req_wdata` during WAIT.
  - Required: the DPI call uses the captured values.
